// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - program counter, FETCH/EXEC phase machine and conditional jump resolution
//
// Purpose:
//   Owns the program counter and the FETCH/EXEC/HALT phase machine. It drives
//   the write-enable of the external C/Z flag register, reads the flag Q
//   outputs back and resolves conditional jumps from them.
//
// Optional feature:
//   BRANCH_HISTORY_EN - when defined, hist is a 4-bit shift register of
//   conditional-jump outcomes; otherwise hist is tied to zero.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high
//   enable    in   global run; low freezes all state and forces flags_we=0
//   opcode    in   [3:0] opcode of the current instruction (valid in EXEC)
//   target    in   [ADDR_W-1:0] jump address (valid in EXEC)
//   c_flag    in   carry flag Q
//   z_flag    in   zero flag Q
//   pc        out  [ADDR_W-1:0] program counter
//   phase     out  0=FETCH, 1=EXEC (0 in HALT)
//   flags_we  out  C/Z flag register write-enable (combinational)
//   taken     out  previous EXEC took a jump
//   halted    out  machine is in HALT
//   hist      out  [3:0] conditional branch history

module branch_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] target,
    input  logic              c_flag,
    input  logic              z_flag,
    output logic [ADDR_W-1:0] pc,
    output logic              phase,
    output logic              flags_we,
    output logic              taken,
    output logic              halted,
    output logic [3:0]        hist
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t state;

    logic is_cjmp;
    logic is_jmp;
    logic is_hlt;
    logic cond_true;

    assign is_cjmp = (opcode[3:2] == 2'b00);
    assign is_jmp  = (opcode == 4'b1111);
    assign is_hlt  = (opcode == 4'b1110);

    // Flags are the Q outputs as they stand in this EXEC cycle; a write from
    // the previous instruction's EXEC edge is already visible here.
    always_comb begin
        cond_true = 1'b0;
        case (opcode[1:0])
            2'b00:   cond_true = c_flag;
            2'b01:   cond_true = ~c_flag;
            2'b10:   cond_true = z_flag;
            default: cond_true = ~z_flag;
        endcase
    end

    assign flags_we = enable && (state == S_EXEC) && !is_cjmp && !is_jmp && !is_hlt;
    assign phase    = (state == S_EXEC);
    assign halted   = (state == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= ADDR_W'(RESET_PC);
            state <= S_FETCH;
            taken <= 1'b0;
        end else if (enable) begin
            case (state)
                S_FETCH: begin
                    pc    <= pc + ADDR_W'(1);
                    state <= S_EXEC;
                    taken <= 1'b0;
                end
                S_EXEC: begin
                    if (is_hlt) begin
                        state <= S_HALT;
                        taken <= 1'b0;
                    end else if (is_jmp || (is_cjmp && cond_true)) begin
                        pc    <= target;
                        state <= S_FETCH;
                        taken <= 1'b1;
                    end else begin
                        pc    <= pc + ADDR_W'(1);
                        state <= S_FETCH;
                        taken <= 1'b0;
                    end
                end
                default: begin
                    // HALT is sticky until reset; everything stays frozen.
                    state <= S_HALT;
                end
            endcase
        end
    end

`ifdef BRANCH_HISTORY_EN
    logic [3:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 4'b0000;
        end else if (enable && (state == S_EXEC) && is_cjmp) begin
            hist_q <= {hist_q[2:0], cond_true};
        end
    end

    assign hist = hist_q;
`else
    assign hist = 4'b0000;
`endif

endmodule
